// File: rtl/sar_search.sv
// =============================================================================
// sar_search : MSB-first successive-approximation search against an external
//              unsigned comparator (unknown on a, guess on b).
// Optional feature macro: SAR_EARLY_EXIT_EN (terminate as soon as eq is seen).
// Revision   : 1.0
// =============================================================================
`default_nettype none

module sar_search #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            gt,
  input  logic            eq,
  output logic [SIZE-1:0] guess,
  output logic [SIZE-1:0] result,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int              IW      = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IW-1:0]   IDX_TOP = IW'(SIZE - 1);
  localparam logic [SIZE-1:0] MSB     = SIZE'(1) << (SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t          state_q,  state_d;
  logic [SIZE-1:0] guess_q,  guess_d;
  logic [SIZE-1:0] result_q, result_d;
  logic [IW-1:0]   idx_q,    idx_d;
  logic            err_q,    err_d;

  logic            keep;
  logic [SIZE-1:0] bit_mask;
  logic [SIZE-1:0] trial;

  // Without early exit, equality simply means the trial bit belongs in the answer.
`ifdef SAR_EARLY_EXIT_EN
  assign keep = gt;
`else
  assign keep = gt | eq;
`endif

  assign bit_mask = SIZE'(1) << idx_q;
  assign trial    = keep ? (guess_q | bit_mask) : (guess_q & ~bit_mask);

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    result_d = result_q;
    idx_d    = idx_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEARCH;
          guess_d = MSB;
          idx_d   = IDX_TOP;
          err_d   = 1'b0;
        end
      end

      ST_SEARCH: begin
        if (gt && eq) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = ST_DONE;
        end
`ifdef SAR_EARLY_EXIT_EN
        else if (eq) begin
          result_d = guess_q;
          state_d  = ST_DONE;
        end
`endif
        else if (idx_q == '0) begin
          // gt on the last trial means the unknown lies above every reachable value.
          guess_d  = trial;
          result_d = trial;
          err_d    = gt;
          state_d  = ST_DONE;
        end else begin
          guess_d = trial | (bit_mask >> 1);
          idx_d   = idx_q - IW'(1);
        end
      end

      ST_DONE: begin
        idx_d   = IDX_TOP;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      guess_q  <= '0;
      result_q <= '0;
      idx_q    <= IDX_TOP;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign err    = err_q;
  assign busy   = (state_q == ST_SEARCH);
  assign done   = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sar_search.sv
// =============================================================================
// tb_sar_search : randomized scoreboard bench for sar_search with a behavioural
//                 comparator and search model.
// Revision      : 1.0
// =============================================================================
`default_nettype none

module tb_sar_search;

  localparam int N = 4;

  typedef struct packed {
    logic [15:0]       result;
    logic              err;
    logic [4:0]        trials;
    logic [15:0][15:0] g;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         gt;
  logic         eq;
  logic [N-1:0] guess;
  logic [N-1:0] result;
  logic         busy;
  logic         done;
  logic         err;

  logic [N-1:0] unk;
  int           mode;      // 0: honest comparator, 1: gt stuck high, 2: gt and eq stuck high

  int   n_pass  = 0;
  int   n_total = 0;
  int   done_cnt = 0;
  int   searches = 0;
  exp_t sb_q[$];

  logic [15:0] cap[16];
  int          ntr = 0;

  always #5 clk = ~clk;

  assign gt = (mode == 1 || mode == 2) ? 1'b1 : (unk > guess);
  assign eq = (mode == 2) ? 1'b1 : ((mode == 1) ? 1'b0 : (unk == guess));

  sar_search #(.SIZE(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .gt      (gt),
    .eq      (eq),
    .guess   (guess),
    .result  (result),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Binary search from first principles: trial k keeps the unknown's top k-1
  // bits and probes the next one.
  function automatic exp_t model(input int u, input int m);
    exp_t e;
    int   sh;
    int   g;
    e = '0;
    if (m == 2) begin
      e.trials = 5'd1;
      e.g[0]   = 16'(1 << (N - 1));
      e.result = 16'd0;
      e.err    = 1'b1;
    end else if (m == 1) begin
      for (int k = 1; k <= N; k++) e.g[k-1] = 16'(((1 << k) - 1) << (N - k));
      e.trials = 5'(N);
      e.result = 16'((1 << N) - 1);
      e.err    = 1'b1;
    end else begin
      e.result = 16'(u);
      e.err    = 1'b0;
      for (int k = 1; k <= N; k++) begin
        sh         = N - k;
        g          = ((u >> (sh + 1)) << (sh + 1)) | (1 << sh);
        e.g[k-1]   = 16'(g);
        e.trials   = 5'(k);
`ifdef SAR_EARLY_EXIT_EN
        if (g == u) break;
`endif
      end
    end
    return e;
  endfunction

  // Monitor: collects the guesses seen while busy and scores each done pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      ntr = 0;
    end else begin
      if (busy) begin
        if (ntr < 16) cap[ntr] = 16'(guess);
        ntr++;
      end
      if (done) begin
        exp_t e;
        done_cnt++;
        check("busy_low_in_done", int'(busy), 0);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("result", int'(result), int'(e.result));
          check("err", int'(err), int'(e.err));
          check("search_cycles", ntr, int'(e.trials));
          for (int i = 0; i < 16; i++)
            if (i < int'(e.trials) && i < ntr)
              check($sformatf("guess[%0d]", i), int'(cap[i]), int'(e.g[i]));
        end
        ntr = 0;
      end
    end
  end

  task automatic run_search(input int u, input int m, input bit hold);
    int   n;
    bit   got;
    exp_t e;
    unk  = N'(u);
    mode = m;
    e    = model(u, m);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", int'(got), 1);
    check("start_to_done_edges", n, int'(e.trials));
    if (got) searches++;
    repeat (2) @(negedge clk);
    #1;
    check("done_pulse_count", done_cnt, searches);
    check("busy_idle", int'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_guess"},  int'(guess),  0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_busy"},   int'(busy),   0);
    check({tag, "_done"},   int'(done),   0);
    check({tag, "_err"},    int'(err),    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u;
    int m;
    reset_n = 1'b0;
    start   = 1'b0;
    unk     = '0;
    mode    = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    run_search(11, 0, 1'b0);
    run_search(8,  0, 1'b0);
    run_search(0,  0, 1'b0);
    run_search(15, 0, 1'b0);
    run_search(7,  1, 1'b0);
    run_search(3,  2, 1'b0);
    run_search(6,  0, 1'b1);

    // Asynchronous reset in the middle of a search, then a clean retry.
    unk  = N'(5);
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    check("midreset_no_done", done_cnt, searches);
    run_search(5, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      u = int'($urandom_range(0, (1 << N) - 1));
      m = int'($urandom_range(0, 9));
      m = (m == 8) ? 1 : ((m == 9) ? 2 : 0);
      run_search(u, m, ($urandom_range(0, 3) == 0));
    end

    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
